// File: rtl/test4_pkg.sv
// Shared types, constants and the seven-segment decoder for the hardware test 4 SMA path.
package test4_pkg;

    localparam int          SAMPLE_W  = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [6:0]          seg7_t;

    // Active-low segments, bit 6..0 = g..a.
    function automatic seg7_t hex_to_seg7(input logic [3:0] nibble);
        seg7_t seg;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sma_window.sv
// Sliding window of the last 2**WIN_LOG2 samples with a running sum, fill count
// and SMA trend flags. The divisor is always the full window length.
module sma_window
    import test4_pkg::*;
#(
    parameter int WIN_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    input  sample_t           sample,
    output sample_t           sma,
    output logic [WIN_LOG2:0] count,
    output logic              full,
    output logic              rising,
    output logic              falling
);

    localparam int DEPTH = 1 << WIN_LOG2;
    localparam int SUM_W = SAMPLE_W + WIN_LOG2;

    sample_t                ring_q [DEPTH];
    logic [WIN_LOG2-1:0]    wr_ptr_q;
    logic [SUM_W-1:0]       sum_q;
    logic [SUM_W-1:0]       sum_d;
    logic [WIN_LOG2:0]      count_q;
    logic                   rising_q;
    logic                   falling_q;
    sample_t                oldest;
    sample_t                sma_d;

    // Entry being overwritten leaves the sum as the new sample enters it,
    // so the sum stays exact across wrap-around.
    always_comb begin
        oldest = ring_q[wr_ptr_q];
        sum_d  = sum_q + SUM_W'(sample) - SUM_W'(oldest);
        sma_d  = sum_d[SUM_W-1:WIN_LOG2];
    end

    // One register per ring entry; the whole window is discarded on reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ring
            always_ff @(posedge clk) begin
                if (rst) begin
                    ring_q[gi] <= '0;
                end else if (strobe && (wr_ptr_q == WIN_LOG2'(gi))) begin
                    ring_q[gi] <= sample;
                end
            end
        end
    endgenerate

    // Sum, pointer, saturating fill count and trend flags advance per strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q     <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rising_q  <= 1'b0;
            falling_q <= 1'b0;
        end else if (strobe) begin
            sum_q    <= sum_d;
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (count_q != (WIN_LOG2 + 1)'(DEPTH)) begin
                count_q <= count_q + 1'b1;
            end
            rising_q  <= (sma_d > sma);
            falling_q <= (sma_d < sma);
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        sma     = sum_q[SUM_W-1:WIN_LOG2];
        count   = count_q;
        full    = (count_q == (WIN_LOG2 + 1)'(DEPTH));
        rising  = rising_q;
        falling = falling_q;
    end

endmodule

// File: rtl/test4_top.sv
// Board top for hardware test 4: LFSR or switch samples feed an SMA window;
// SMA on red LEDs, status on green LEDs, sample and SMA on the hex displays.
module test4_top
    import test4_pkg::*;
#(
    parameter int          TICK_DIV  = 1,
    parameter int          WIN_LOG2  = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        CLOCK2_50,
    input  logic        CLOCK3_50,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    output logic [15:0] LEDR,
    output logic [7:0]  LEDG,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic clk;
    logic rst;
    assign clk = CLOCK_50;
    assign rst = SW[17];

    // Spare clocks and keys are deliberately left unconnected to any logic.
    logic unused_inputs;
    assign unused_inputs = ^{CLOCK2_50, CLOCK3_50, KEY};

    logic [TICK_W-1:0]  tick_q;
    logic [TICK_W-1:0]  tick_d;
    logic               strobe;
    sample_t            lfsr_q;
    sample_t            lfsr_d;
    sample_t            sample_sel;
    sample_t            last_sample_q;
    logic               heartbeat_q;

    sample_t            sma;
    logic [WIN_LOG2:0]  count;
    logic               full;
    logic               rising;
    logic               falling;

    seg7_t              seg_sample [4];
    seg7_t              seg_sma    [4];

    // Strobe on the last count of the tick divider; TICK_DIV=1 strobes every cycle.
    always_comb begin
        strobe     = (tick_q == TICK_W'(TICK_DIV - 1));
        tick_d     = strobe ? '0 : tick_q + 1'b1;
        lfsr_d     = strobe ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0)) : lfsr_q;
        sample_sel = SW[16] ? SW[15:0] : lfsr_q;
    end

    // Divider, price generator, displayed sample and heartbeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q        <= '0;
            lfsr_q        <= LFSR_SEED;
            last_sample_q <= '0;
            heartbeat_q   <= 1'b0;
        end else begin
            tick_q <= tick_d;
            lfsr_q <= lfsr_d;
            if (strobe) begin
                last_sample_q <= sample_sel;
                heartbeat_q   <= ~heartbeat_q;
            end
        end
    end

    sma_window #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_sma_window (
        .clk     (clk),
        .rst     (rst),
        .strobe  (strobe),
        .sample  (sample_sel),
        .sma     (sma),
        .count   (count),
        .full    (full),
        .rising  (rising),
        .falling (falling)
    );

    // Nibble-wise decode of the registered sample and SMA.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_seg
            assign seg_sample[gi] = hex_to_seg7(last_sample_q[4*gi +: 4]);
            assign seg_sma[gi]    = hex_to_seg7(sma[4*gi +: 4]);
        end
    endgenerate

    // LED and display mapping.
    always_comb begin
        LEDR = sma;
        LEDG = {heartbeat_q, falling, rising, full, 4'(count)};
        HEX0 = seg_sample[0];
        HEX1 = seg_sample[1];
        HEX2 = seg_sample[2];
        HEX3 = seg_sample[3];
        HEX4 = seg_sma[0];
        HEX5 = seg_sma[1];
        HEX6 = seg_sma[2];
        HEX7 = seg_sma[3];
    end

endmodule

// File: tb/tb_test4_top.sv
// Table-driven bench for test4_top (TICK_DIV=1) plus a TICK_DIV=4 instance.
module tb_test4_top;

    logic        clk = 1'b0;
    logic [17:0] sw1 = 18'h20000;
    logic [17:0] sw4 = 18'h20000;
    logic [3:0]  key = 4'hF;

    logic [15:0] ledr1, ledr4;
    logic [7:0]  ledg1, ledg4;
    logic [6:0]  h1_0, h1_1, h1_2, h1_3, h1_4, h1_5, h1_6, h1_7;
    logic [6:0]  h4_0, h4_1, h4_2, h4_3, h4_4, h4_5, h4_6, h4_7;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    test4_top #(.TICK_DIV(1)) dut1 (
        .CLOCK_50(clk), .CLOCK2_50(1'b0), .CLOCK3_50(1'b0), .KEY(key), .SW(sw1),
        .LEDR(ledr1), .LEDG(ledg1),
        .HEX0(h1_0), .HEX1(h1_1), .HEX2(h1_2), .HEX3(h1_3),
        .HEX4(h1_4), .HEX5(h1_5), .HEX6(h1_6), .HEX7(h1_7)
    );

    test4_top #(.TICK_DIV(4)) dut4 (
        .CLOCK_50(clk), .CLOCK2_50(1'b0), .CLOCK3_50(1'b0), .KEY(key), .SW(sw4),
        .LEDR(ledr4), .LEDG(ledg4),
        .HEX0(h4_0), .HEX1(h4_1), .HEX2(h4_2), .HEX3(h4_3),
        .HEX4(h4_4), .HEX5(h4_5), .HEX6(h4_6), .HEX7(h4_7)
    );

    typedef struct {
        logic        rst;
        logic        man;
        logic [15:0] val;
        logic [15:0] exp_ledr;
        logic [7:0]  exp_ledg;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic man, input logic [15:0] val,
                       input logic [15:0] exp_ledr, input logic [7:0] exp_ledg);
        vec_t v;
        v.rst = rst; v.man = man; v.val = val; v.exp_ledr = exp_ledr; v.exp_ledg = exp_ledg;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // ---- table: TICK_DIV=1 instance, one vector per clock edge ----
        add(1, 0, 16'h0000, 16'h0000, 8'h00);           // reset
        add(0, 0, 16'h0000, 16'h159C, 8'hA1);           // LFSR sample ACE1
        add(0, 0, 16'h0000, 16'h31EA, 8'h22);           // LFSR sample E270
        add(1, 0, 16'h0000, 16'h0000, 8'h00);
        for (int k = 1; k <= 7; k++)                    // manual fill with 8
            add(0, 1, 16'h0008, 16'(k), 8'h20 | 8'(k) | ((k % 2) ? 8'h80 : 8'h00));
        add(0, 1, 16'h0008, 16'h0008, 8'h38);           // window full, rising
        for (int j = 1; j <= 8; j++)                    // drain with 0
            add(0, 1, 16'h0000, 16'(8 - j), (j % 2) ? 8'hD8 : 8'h58);
        add(0, 1, 16'hFFFF, 16'h1FFF, 8'hB8);
        add(0, 1, 16'hFFFF, 16'h3FFF, 8'h38);
        add(0, 1, 16'hFFFF, 16'h5FFF, 8'hB8);
        add(0, 1, 16'hFFFF, 16'h7FFF, 8'h38);
        add(0, 1, 16'hFFFF, 16'h9FFF, 8'hB8);
        add(0, 1, 16'hFFFF, 16'hBFFF, 8'h38);
        add(0, 1, 16'hFFFF, 16'hDFFF, 8'hB8);
        add(0, 1, 16'hFFFF, 16'hFFFF, 8'h38);
        for (int m = 9; m <= 16; m++)                   // equal SMA: no trend
            add(0, 1, 16'hFFFF, 16'hFFFF, (m % 2) ? 8'h98 : 8'h18);
        add(1, 1, 16'h0000, 16'h0000, 8'h00);
        for (int k = 1; k <= 5; k++)
            add(0, 1, 16'h0008, 16'(k), 8'h20 | 8'(k) | ((k % 2) ? 8'h80 : 8'h00));
        add(1, 1, 16'h0008, 16'h0000, 8'h00);           // reset mid-window
        add(0, 1, 16'h0010, 16'h0002, 8'hA1);
        add(1, 0, 16'h0000, 16'h0000, 8'h00);           // LFSR reseeded
        add(0, 0, 16'h0000, 16'h159C, 8'hA1);

        // ---- hand sequence: reset display and first LFSR sample decode ----
        @(negedge clk);
        sw1 = 18'h20000;
        step();
        chk("rst_ledr", ledr1, 16'h0000);
        chk("rst_ledg", ledg1, 8'h00);
        chk("rst_hex", {h1_7, h1_6, h1_5, h1_4, h1_3, h1_2, h1_1, h1_0},
            {8{7'h40}});
        sw1 = 18'h00000;
        step();
        chk("lfsr_hex_sample", {h1_3, h1_2, h1_1, h1_0}, {7'h08, 7'h46, 7'h06, 7'h79});
        chk("lfsr_hex_sma", {h1_7, h1_6, h1_5, h1_4}, {7'h79, 7'h12, 7'h10, 7'h46});

        // ---- table loop ----
        for (int i = 0; i < vecs.size(); i++) begin
            sw1 = {vecs[i].rst, vecs[i].man, vecs[i].val};
            step();
            chk($sformatf("vec%0d_ledr", i), ledr1, vecs[i].exp_ledr);
            chk($sformatf("vec%0d_ledg", i), ledg1, vecs[i].exp_ledg);
        end
        sw1 = 18'h10000;

        // ---- hand sequence: TICK_DIV=4, sampling only at the strobe edge ----
        sw4 = 18'h20000;
        step();
        chk("d4_rst_ledg", ledg4, 8'h00);
        for (int e = 1; e <= 3; e++) begin
            sw4 = 18'h1FFF0;
            step();
            chk($sformatf("d4_idle%0d_ledr", e), ledr4, 16'h0000);
            chk($sformatf("d4_idle%0d_ledg", e), ledg4, 8'h00);
        end
        sw4 = 18'h10020;
        step();
        chk("d4_strobe1_ledr", ledr4, 16'h0004);
        chk("d4_strobe1_ledg", ledg4, 8'hA1);
        chk("d4_strobe1_hex", {h4_1, h4_0}, {7'h24, 7'h40});
        for (int e = 5; e <= 7; e++) begin
            sw4 = 18'h11234;
            step();
            chk($sformatf("d4_hold%0d_ledr", e), ledr4, 16'h0004);
            chk($sformatf("d4_hold%0d_ledg", e), ledg4, 8'hA1);
        end
        sw4 = 18'h10020;
        step();
        chk("d4_strobe2_ledr", ledr4, 16'h0008);
        chk("d4_strobe2_ledg", ledg4, 8'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
